// File: rtl/bootrom_arbiter_if.sv
// AHB-Lite port bundle shared by the boot ROM arbiter and its masters/slave.
// The request half (hsel..hready) flows master -> slave; the response half
// (hreadyout, hrdata, hresp) flows slave -> master.
interface bootrom_arbiter_if;
    logic        hsel;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic [2:0]  hsize;
    logic        hwrite;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic [31:0] hrdata;
    logic        hresp;

    modport master (
        output hsel, htrans, haddr, hsize, hwrite, hwdata, hready,
        input  hreadyout, hrdata, hresp
    );

    modport slave (
        input  hsel, htrans, haddr, hsize, hwrite, hwdata, hready,
        output hreadyout, hrdata, hresp
    );
endinterface

// File: rtl/bootrom_arbiter.sv
// Two-master AHB-Lite arbiter in front of the boot ROM.
// m0 = CPU fetch/data path, m1 = debug/loader path. A request that cannot be
// issued to the ROM immediately is parked in a one-deep pending register and
// replayed at the next issue point; the owning master is stalled meanwhile.
// Optional feature: define BOOTROM_ARB_RR_EN for round-robin conflict
// resolution; otherwise m0 has fixed priority.
module bootrom_arbiter #(
    parameter int NUM_PEND = 1
) (
    input  logic              clk,
    input  logic              rst,
    bootrom_arbiter_if.slave  m0,
    bootrom_arbiter_if.slave  m1,
    bootrom_arbiter_if.master s
);
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {ST_IDLE, ST_DATA0, ST_DATA1} state_t;

    state_t      state_reg, state_next;
    logic        last_reg, last_next;

    logic        req        [2];
    logic [31:0] live_addr  [2];
    logic [2:0]  live_size  [2];
    logic        live_write [2];

    logic        pend_v_reg     [2];
    logic [31:0] pend_addr_reg  [2];
    logic [2:0]  pend_size_reg  [2];
    logic        pend_write_reg [2];

    logic        issue_pt;
    logic        cand0, cand1;
    logic        grant_v;
    logic        grant_id;
    logic [31:0] grant_addr;
    logic [2:0]  grant_size;
    logic        grant_write;

    // Only a single pending slot per master is supported: the master stalls while busy.
    generate
        if (NUM_PEND != 1) begin : g_bad_num_pend
            $error("bootrom_arbiter: NUM_PEND must be 1");
        end
    endgenerate

    assign live_addr[0]  = m0.haddr;
    assign live_size[0]  = m0.hsize;
    assign live_write[0] = m0.hwrite;
    assign live_addr[1]  = m1.haddr;
    assign live_size[1]  = m1.hsize;
    assign live_write[1] = m1.hwrite;

    assign req[0] = m0.hsel && m0.hready && (m0.htrans == HTRANS_NONSEQ || m0.htrans == HTRANS_SEQ);
    assign req[1] = m1.hsel && m1.hready && (m1.htrans == HTRANS_NONSEQ || m1.htrans == HTRANS_SEQ);

    // Pick the winner at an issue point from pending entries plus live requests.
    always_comb begin
        issue_pt = !rst && (state_reg == ST_IDLE || s.hreadyout);
        cand0    = pend_v_reg[0] || req[0];
        cand1    = pend_v_reg[1] || req[1];
        grant_v  = 1'b0;
        grant_id = 1'b0;
        if (issue_pt && (cand0 || cand1)) begin
            grant_v = 1'b1;
            if (cand0 && cand1) begin
`ifdef BOOTROM_ARB_RR_EN
                grant_id = ~last_reg;
`else
                grant_id = 1'b0;
`endif
            end else begin
                grant_id = cand1;
            end
        end
    end

    // Winner's address-phase attributes: a parked request takes precedence over live inputs.
    always_comb begin
        grant_addr  = live_addr[grant_id];
        grant_size  = live_size[grant_id];
        grant_write = live_write[grant_id];
        if (pend_v_reg[grant_id]) begin
            grant_addr  = pend_addr_reg[grant_id];
            grant_size  = pend_size_reg[grant_id];
            grant_write = pend_write_reg[grant_id];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_pend
            // Park a live request that loses (or arrives off an issue point); release it when issued.
            always_ff @(posedge clk) begin
                if (rst) begin
                    pend_v_reg[gi]     <= 1'b0;
                    pend_addr_reg[gi]  <= '0;
                    pend_size_reg[gi]  <= '0;
                    pend_write_reg[gi] <= 1'b0;
                end else if (grant_v && grant_id == 1'(gi)) begin
                    pend_v_reg[gi] <= 1'b0;
                end else if (req[gi]) begin
                    pend_v_reg[gi]     <= 1'b1;
                    pend_addr_reg[gi]  <= live_addr[gi];
                    pend_size_reg[gi]  <= live_size[gi];
                    pend_write_reg[gi] <= live_write[gi];
                end
            end
        end
    endgenerate

    // State register and last-granted master.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            last_reg  <= 1'b1;
        end else begin
            state_reg <= state_next;
            last_reg  <= last_next;
        end
    end

    // Next state: at each issue point the ROM data phase goes to the winner, or idles.
    always_comb begin
        state_next = state_reg;
        last_next  = last_reg;
        if (issue_pt) begin
            if (grant_v) begin
                state_next = grant_id ? ST_DATA1 : ST_DATA0;
                last_next  = grant_id;
            end else begin
                state_next = ST_IDLE;
            end
        end
    end

    // Request toward the ROM: one NONSEQ per issued transfer, write data from the data-phase owner.
    always_comb begin
        s.hsel   = grant_v;
        s.htrans = grant_v ? HTRANS_NONSEQ : HTRANS_IDLE;
        s.haddr  = grant_v ? grant_addr : '0;
        s.hsize  = grant_v ? grant_size : '0;
        s.hwrite = grant_v ? grant_write : 1'b0;
        s.hready = (state_reg == ST_IDLE) ? 1'b1 : s.hreadyout;
        case (state_reg)
            ST_DATA0: s.hwdata = m0.hwdata;
            ST_DATA1: s.hwdata = m1.hwdata;
            default:  s.hwdata = '0;
        endcase
    end

    // Responses: stall a master while parked or while its ROM data phase waits.
    always_comb begin
        m0.hreadyout = !(pend_v_reg[0] || (state_reg == ST_DATA0 && !s.hreadyout));
        m1.hreadyout = !(pend_v_reg[1] || (state_reg == ST_DATA1 && !s.hreadyout));
        m0.hrdata    = '0;
        m0.hresp     = 1'b0;
        m1.hrdata    = '0;
        m1.hresp     = 1'b0;
        if (state_reg == ST_DATA0) begin
            m0.hrdata = s.hrdata;
            m0.hresp  = s.hresp;
        end
        if (state_reg == ST_DATA1) begin
            m1.hrdata = s.hrdata;
            m1.hresp  = s.hresp;
        end
    end
endmodule

// File: tb/tb_bootrom_arbiter.sv
// Bench for bootrom_arbiter: table of per-cycle vectors plus hand-written
// sequences for byte reads, error responses, writes, mid-transfer reset and
// repeated conflicts. A one-wait-state ROM model answers on the slave side.
module tb_bootrom_arbiter;
    localparam logic [1:0] I = 2'b00;
    localparam logic [1:0] N = 2'b10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bootrom_arbiter_if m0_bus ();
    bootrom_arbiter_if m1_bus ();
    bootrom_arbiter_if s_bus ();

    bootrom_arbiter #(.NUM_PEND(1)) dut (
        .clk (clk),
        .rst (rst),
        .m0  (m0_bus),
        .m1  (m1_bus),
        .s   (s_bus)
    );

    // Masters see the bus HREADY they are given back.
    assign m0_bus.hready = m0_bus.hreadyout;
    assign m1_bus.hready = m1_bus.hreadyout;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'hC0DE_0000 ^ {a[31:2], 2'b00};
    endfunction

    // ROM model: one wait state, ERROR for addresses at or above 0x1000, zero data for writes.
    logic [1:0]  rom_ph   = 2'd0;
    logic [31:0] rom_addr = '0;
    logic        rom_wr   = 1'b0;
    always @(posedge clk) begin
        if (rst) begin
            rom_ph <= 2'd0;
        end else if (rom_ph == 2'd1) begin
            rom_ph <= 2'd2;
        end else if (s_bus.hsel && s_bus.htrans == N && s_bus.hready) begin
            rom_ph   <= 2'd1;
            rom_addr <= s_bus.haddr;
            rom_wr   <= s_bus.hwrite;
        end else begin
            rom_ph <= 2'd0;
        end
    end
    assign s_bus.hreadyout = (rom_ph != 2'd1);
    assign s_bus.hresp     = (rom_ph != 2'd0) && (rom_addr >= 32'h1000);
    assign s_bus.hrdata    = (rom_ph == 2'd2 && !rom_wr && rom_addr < 32'h1000) ? rom_word(rom_addr) : '0;

    typedef struct {
        logic [1:0]  t0;
        logic [31:0] a0;
        logic [1:0]  t1;
        logic [31:0] a1;
        logic        r0;
        logic        r1;
        logic [1:0]  st;
        logic [31:0] sa;
        logic [31:0] d0;
        logic [31:0] d1;
    } vec_t;

    vec_t vecs[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual=%h required=%h", name, act, exp);
    endtask

    task automatic add(input logic [1:0] t0, input logic [31:0] a0,
                       input logic [1:0] t1, input logic [31:0] a1,
                       input logic r0, input logic r1,
                       input logic [1:0] st, input logic [31:0] sa,
                       input logic [31:0] d0, input logic [31:0] d1);
        vec_t v;
        v.t0 = t0; v.a0 = a0; v.t1 = t1; v.a1 = a1;
        v.r0 = r0; v.r1 = r1; v.st = st; v.sa = sa; v.d0 = d0; v.d1 = d1;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [1:0] t0, input logic [31:0] a0,
                         input logic [1:0] t1, input logic [31:0] a1,
                         input logic [2:0] sz1, input logic w1);
        m0_bus.hsel   = (t0 != I);
        m0_bus.htrans = t0;
        m0_bus.haddr  = a0;
        m0_bus.hsize  = 3'd2;
        m0_bus.hwrite = 1'b0;
        m1_bus.hsel   = (t1 != I);
        m1_bus.htrans = t1;
        m1_bus.haddr  = a1;
        m1_bus.hsize  = sz1;
        m1_bus.hwrite = w1;
    endtask

    task automatic step(input logic [1:0] t0, input logic [31:0] a0,
                        input logic [1:0] t1, input logic [31:0] a1,
                        input logic [2:0] sz1, input logic w1);
        drive(t0, a0, t1, a1, sz1, w1);
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_rows();
        add(I, 0, I, 0, 1, 1, I, 0, 0, 0);
    endtask

    initial begin
        logic [31:0] a0, a1;
        logic [31:0] seen [2];
        int          nseen;
        logic        got0, got1;

        m0_bus.hwdata = 32'hAAAA_0000;
        m1_bus.hwdata = 32'hBBBB_1111;
        rst = 1'b1;
        drive(I, 0, I, 0, 3'd2, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_m0_hready", 32'(m0_bus.hreadyout), 32'd1);
        chk("reset_m1_hready", 32'(m1_bus.hreadyout), 32'd1);
        chk("reset_m0_hrdata", m0_bus.hrdata, 32'd0);
        chk("reset_m1_hresp", 32'(m1_bus.hresp), 32'd0);
        chk("reset_s_htrans", 32'(s_bus.htrans), 32'(I));
        chk("reset_s_hsel", 32'(s_bus.hsel), 32'd0);
        chk("reset_s_hready", 32'(s_bus.hready), 32'd1);
        tick();
        rst = 1'b0;

        // Conflict 0x10/0x20 with last=m1: m0 wins in both modes, m1 replayed 2 cycles later.
        add(N, 32'h10, N, 32'h20, 1, 1, N, 32'h10, 0, 0);
        add(I, 0, I, 0, 0, 0, I, 0, 0, 0);
        add(I, 0, I, 0, 1, 0, N, 32'h20, rom_word(32'h10), 0);
        add(I, 0, I, 0, 1, 0, I, 0, 0, 0);
        add(I, 0, I, 0, 1, 1, I, 0, 0, rom_word(32'h20));
        idle_rows();
        // Single uncontended m0 read of word 0.
        add(N, 32'h0, I, 0, 1, 1, N, 32'h0, 0, 0);
        add(I, 0, I, 0, 0, 1, I, 0, 0, 0);
        add(I, 0, I, 0, 1, 1, I, 0, rom_word(32'h0), 0);
        idle_rows();
        // Same conflict again, now with last=m0.
`ifdef BOOTROM_ARB_RR_EN
        add(N, 32'h10, N, 32'h20, 1, 1, N, 32'h20, 0, 0);
        add(I, 0, I, 0, 0, 0, I, 0, 0, 0);
        add(I, 0, I, 0, 0, 1, N, 32'h10, 0, rom_word(32'h20));
        add(I, 0, I, 0, 0, 1, I, 0, 0, 0);
        add(I, 0, I, 0, 1, 1, I, 0, rom_word(32'h10), 0);
        idle_rows();
`else
        add(N, 32'h10, N, 32'h20, 1, 1, N, 32'h10, 0, 0);
        add(I, 0, I, 0, 0, 0, I, 0, 0, 0);
        add(I, 0, I, 0, 1, 0, N, 32'h20, rom_word(32'h10), 0);
        add(I, 0, I, 0, 1, 0, I, 0, 0, 0);
        add(I, 0, I, 0, 1, 1, I, 0, 0, rom_word(32'h20));
        idle_rows();
`endif
        // m0 back-to-back 0x0,0x4,0x8 with m1 0x40 arriving during the first.
        add(N, 32'h0, I, 0, 1, 1, N, 32'h0, 0, 0);
        add(N, 32'h4, N, 32'h40, 0, 1, I, 0, 0, 0);
`ifdef BOOTROM_ARB_RR_EN
        add(N, 32'h4, I, 0, 1, 0, N, 32'h40, rom_word(32'h0), 0);
        add(N, 32'h8, I, 0, 0, 0, I, 0, 0, 0);
        add(N, 32'h8, I, 0, 0, 1, N, 32'h4, 0, rom_word(32'h40));
        add(N, 32'h8, I, 0, 0, 1, I, 0, 0, 0);
        add(N, 32'h8, I, 0, 1, 1, N, 32'h8, rom_word(32'h4), 0);
        add(I, 0, I, 0, 0, 1, I, 0, 0, 0);
        add(I, 0, I, 0, 1, 1, I, 0, rom_word(32'h8), 0);
        idle_rows();
`else
        add(N, 32'h4, I, 0, 1, 0, N, 32'h4, rom_word(32'h0), 0);
        add(N, 32'h8, I, 0, 0, 0, I, 0, 0, 0);
        add(N, 32'h8, I, 0, 1, 0, N, 32'h8, rom_word(32'h4), 0);
        add(I, 0, I, 0, 0, 0, I, 0, 0, 0);
        add(I, 0, I, 0, 1, 0, N, 32'h40, rom_word(32'h8), 0);
        add(I, 0, I, 0, 1, 0, I, 0, 0, 0);
        add(I, 0, I, 0, 1, 1, I, 0, 0, rom_word(32'h40));
        idle_rows();
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].t0, vecs[i].a0, vecs[i].t1, vecs[i].a1, 3'd2, 1'b0);
            $display("row %0d: m0_hready=%b m1_hready=%b s_htrans=%b s_haddr=%h m0_hrdata=%h m1_hrdata=%h",
                     i, m0_bus.hreadyout, m1_bus.hreadyout, s_bus.htrans, s_bus.haddr,
                     m0_bus.hrdata, m1_bus.hrdata);
            chk($sformatf("row%0d_m0_hready", i), 32'(m0_bus.hreadyout), 32'(vecs[i].r0));
            chk($sformatf("row%0d_m1_hready", i), 32'(m1_bus.hreadyout), 32'(vecs[i].r1));
            chk($sformatf("row%0d_s_htrans", i), 32'(s_bus.htrans), 32'(vecs[i].st));
            if (vecs[i].st == N) chk($sformatf("row%0d_s_haddr", i), s_bus.haddr, vecs[i].sa);
            chk($sformatf("row%0d_m0_hrdata", i), m0_bus.hrdata, vecs[i].d0);
            chk($sformatf("row%0d_m1_hrdata", i), m1_bus.hrdata, vecs[i].d1);
            tick();
        end

        // Byte read from m1: size and low address bits forwarded, full word returned.
        step(I, 0, N, 32'h3, 3'd0, 1'b0);
        $display("byte read: s_haddr=%h s_hsize=%0d", s_bus.haddr, s_bus.hsize);
        chk("byte_s_haddr", s_bus.haddr, 32'h3);
        chk("byte_s_hsize", 32'(s_bus.hsize), 32'd0);
        chk("byte_s_htrans", 32'(s_bus.htrans), 32'(N));
        tick();
        step(I, 0, I, 0, 3'd2, 1'b0);
        chk("byte_m1_wait", 32'(m1_bus.hreadyout), 32'd0);
        tick();
        step(I, 0, I, 0, 3'd2, 1'b0);
        chk("byte_m1_hready", 32'(m1_bus.hreadyout), 32'd1);
        chk("byte_m1_hrdata", m1_bus.hrdata, rom_word(32'h3));
        tick();
        step(I, 0, I, 0, 3'd2, 1'b0);
        tick();

        // ERROR response passed through on both cycles.
        step(N, 32'h1000, I, 0, 3'd2, 1'b0);
        chk("err_s_haddr", s_bus.haddr, 32'h1000);
        tick();
        step(I, 0, I, 0, 3'd2, 1'b0);
        $display("error response: m0_hready=%b m0_hresp=%b", m0_bus.hreadyout, m0_bus.hresp);
        chk("err_c1_m0_hready", 32'(m0_bus.hreadyout), 32'd0);
        chk("err_c1_m0_hresp", 32'(m0_bus.hresp), 32'd1);
        chk("err_c1_m1_hresp", 32'(m1_bus.hresp), 32'd0);
        tick();
        step(I, 0, I, 0, 3'd2, 1'b0);
        chk("err_c2_m0_hready", 32'(m0_bus.hreadyout), 32'd1);
        chk("err_c2_m0_hresp", 32'(m0_bus.hresp), 32'd1);
        tick();
        step(I, 0, I, 0, 3'd2, 1'b0);
        chk("err_c3_m0_hresp", 32'(m0_bus.hresp), 32'd0);
        tick();

        // Write from m1 passes through with its write data.
        step(I, 0, N, 32'h8, 3'd2, 1'b1);
        $display("write: s_hwrite=%b s_haddr=%h", s_bus.hwrite, s_bus.haddr);
        chk("wr_s_hwrite", 32'(s_bus.hwrite), 32'd1);
        tick();
        step(I, 0, I, 0, 3'd2, 1'b0);
        chk("wr_s_hwdata", s_bus.hwdata, 32'hBBBB_1111);
        tick();
        step(I, 0, I, 0, 3'd2, 1'b0);
        chk("wr_m1_hready", 32'(m1_bus.hreadyout), 32'd1);
        tick();

        // Reset while m1 is parked and m0 owns the data phase.
        step(N, 32'h30, I, 0, 3'd2, 1'b0);
        chk("rstmid_s_haddr", s_bus.haddr, 32'h30);
        tick();
        step(I, 0, N, 32'h34, 3'd2, 1'b0);
        chk("rstmid_m1_accept", 32'(m1_bus.hreadyout), 32'd1);
        tick();
        rst = 1'b1;
        drive(I, 0, I, 0, 3'd2, 1'b0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        $display("after mid reset: m0_hready=%b m1_hready=%b s_htrans=%b",
                 m0_bus.hreadyout, m1_bus.hreadyout, s_bus.htrans);
        chk("rstmid_m0_hready", 32'(m0_bus.hreadyout), 32'd1);
        chk("rstmid_m1_hready", 32'(m1_bus.hreadyout), 32'd1);
        chk("rstmid_s_htrans", 32'(s_bus.htrans), 32'(I));
        chk("rstmid_s_hsel", 32'(s_bus.hsel), 32'd0);
        tick();
        step(I, 0, N, 32'h24, 3'd2, 1'b0);
        chk("fresh_s_haddr", s_bus.haddr, 32'h24);
        tick();
        step(I, 0, I, 0, 3'd2, 1'b0);
        chk("fresh_m1_wait", 32'(m1_bus.hreadyout), 32'd0);
        tick();
        step(I, 0, I, 0, 3'd2, 1'b0);
        chk("fresh_m1_hrdata", m1_bus.hrdata, rom_word(32'h24));
        tick();

        // Repeated conflicts from reset: m0 wins, m1 replay always follows and completes.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            a0 = 32'h100 + 32'(k * 8);
            a1 = 32'h200 + 32'(k * 8);
            seen[0] = '0;
            seen[1] = '0;
            nseen = 0;
            got0 = 1'b0;
            got1 = 1'b0;
            drive(N, a0, N, a1, 3'd2, 1'b0);
            for (int c = 0; c < 12 && !(got0 && got1); c++) begin
                @(negedge clk);
                if (s_bus.hsel && s_bus.htrans == N) begin
                    if (nseen < 2) seen[nseen] = s_bus.haddr;
                    nseen++;
                end
                if (c > 0 && !got0 && m0_bus.hreadyout) begin
                    chk($sformatf("conf%0d_m0_hrdata", k), m0_bus.hrdata, rom_word(a0));
                    got0 = 1'b1;
                end
                if (c > 0 && !got1 && m1_bus.hreadyout) begin
                    chk($sformatf("conf%0d_m1_hrdata", k), m1_bus.hrdata, rom_word(a1));
                    got1 = 1'b1;
                end
                tick();
                drive(I, 0, I, 0, 3'd2, 1'b0);
            end
            $display("conflict %0d: first=%h second=%h", k, seen[0], seen[1]);
            chk($sformatf("conf%0d_m0_done", k), 32'(got0), 32'd1);
            chk($sformatf("conf%0d_m1_done", k), 32'(got1), 32'd1);
            chk($sformatf("conf%0d_first", k), seen[0], a0);
            chk($sformatf("conf%0d_second", k), seen[1], a1);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
